bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 50 +++++
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the bus arbiter slice.
//   arb_state_e  : arbiter FSM states (IDLE, GRANT, TURNAROUND)
//   MAX_NUM_REQ  : largest number of masters the arbiter is meant to serve
// No ports; imported by bus_arbiter and rr_picker.
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int MAX_NUM_REQ = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. The search begins at the master
// after 'last' and wraps modulo NUM_REQ, so the most recent winner has the
// lowest priority.
// Ports:
//   req    [NUM_REQ-1:0] in  : request vector
//   last   [IDX_W-1:0]   in  : index of the previous winner
//   winner [NUM_REQ-1:0] out : one-hot winner (all-zero when nothing found)
//   idx    [IDX_W-1:0]   out : index of the winner
//   found                out : at least one request was present
// ---------------------------------------------------------------------------
module rr_picker
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    // One extra bit so last + offset can exceed NUM_REQ before wrapping.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = {1'b0, last} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for NUM_REQ masters sharing one memory bus. Every
// ownership change passes through a single all-zero TURNAROUND cycle so the
// tri-state bus can turn around.
// Optional feature: define ARB_TIMEOUT_EN to build the hold counter and the
// preemption logic (an owner is forced off after MAX_HOLD grant cycles unless
// it holds its lock bit or nobody else is waiting). Without the macro a grant
// lasts until the owner drops req, and preempt is tied low.
// Ports:
//   clk          in  : system clock, rising edge
//   rst          in  : asynchronous active-high reset
//   req     [N]  in  : per-master request, held for the whole tenure
//   lock    [N]  in  : per-master preemption lock, only the owner's bit counts
//   grant   [N]  out : registered one-hot ownership, zero when no owner
//   grant_idx    out : index of current owner, holds last owner when idle
//   grant_valid  out : OR of grant
//   preempt      out : one-cycle pulse after a forced grant removal
// ---------------------------------------------------------------------------
module bus_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               preempt
);

    arb_state_e         state, state_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [IDX_W-1:0]   idx_next;
    logic [IDX_W-1:0]   last, last_next;
    logic               preempt_next;
    logic               timeout;

    logic [NUM_REQ-1:0] pick_winner;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req),
        .last   (last),
        .winner (pick_winner),
        .idx    (pick_idx),
        .found  (pick_found)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt, hold_next;

    // Force the owner off on its MAX_HOLD-th grant cycle, but only if it is
    // not locked and somebody else is actually waiting for the bus.
    assign timeout = (hold_cnt == HOLD_W'(MAX_HOLD - 1)) &&
                     !lock[grant_idx] &&
                     ((req & ~grant) != '0);

    // Counter restarts on every entry into GRANT and saturates so a locked
    // owner cannot wrap it around.
    always_comb begin
        hold_next = hold_cnt;
        if (state != GRANT && state_next == GRANT) begin
            hold_next = '0;
        end else if (state == GRANT && hold_cnt != HOLD_W'(MAX_HOLD)) begin
            hold_next = hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_next;
        end
    end
`else
    localparam int unused_max_hold = MAX_HOLD;

    logic unused_lock;
    assign unused_lock = ^lock;
    assign timeout     = 1'b0;
`endif

    // Next-state and next-output logic. IDLE and TURNAROUND share the same
    // exit rule, so TURNAROUND naturally lasts one cycle and a request that
    // arrived on the release edge is picked up there.
    always_comb begin
        state_next   = state;
        grant_next   = grant;
        idx_next     = grant_idx;
        last_next    = last;
        preempt_next = 1'b0;
        case (state)
            IDLE, TURNAROUND: begin
                if (pick_found) begin
                    state_next = GRANT;
                    grant_next = pick_winner;
                    idx_next   = pick_idx;
                    last_next  = pick_idx;
                end else begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            GRANT: begin
                if (!req[grant_idx]) begin
                    state_next = TURNAROUND;
                    grant_next = '0;
                end else if (timeout) begin
                    state_next   = TURNAROUND;
                    grant_next   = '0;
                    preempt_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State and output registers; reset makes master 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
            preempt   <= 1'b0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            grant_idx <= idx_next;
            last      <= last_next;
            preempt   <= preempt_next;
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Scoreboard bench for bus_arbiter (NUM_REQ=4, MAX_HOLD=8). The stimulus
// process drives inputs on the falling edge, advances a behavioural model of
// the arbitration rules and queues the outputs expected after the next rising
// edge. An independent monitor pops and compares just after each rising edge.
// Honours ARB_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 8;

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] grant;
        logic [1:0]   idx;
        logic         valid;
        logic         preempt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         grant_valid;
    logic         preempt;

    bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: who owns the bus, how many grant cycles it has had,
    // the most recent winner and the reported index.
    int m_owner   = -1;
    int m_owned   = 0;
    int m_last    = N - 1;
    int m_idx     = 0;
    bit m_preempt = 1'b0;

    int rem[N] = '{default: 0};

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (from + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic r_rst, input logic [N-1:0] r_req,
                             input logic [N-1:0] r_lock);
        logic [N-1:0] own_mask;
        bit           pre;
        int           w;
        if (r_rst) begin
            m_owner   = -1;
            m_owned   = 0;
            m_last    = N - 1;
            m_idx     = 0;
            m_preempt = 1'b0;
        end else begin
            pre = 1'b0;
            if (m_owner >= 0) begin
                own_mask = '0;
                own_mask[m_owner] = 1'b1;
                if (!r_req[m_owner]) begin
                    m_owner = -1;
                end else if (TIMEOUT && m_owned == HOLD && !r_lock[m_owner] &&
                             ((r_req & ~own_mask) != '0)) begin
                    m_owner = -1;
                    pre     = 1'b1;
                end else if (m_owned <= HOLD) begin
                    m_owned++;
                end
            end else begin
                w = pick(r_req, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_idx   = w;
                    m_last  = w;
                    m_owned = 1;
                end
            end
            m_preempt = pre;
        end
    endtask

    function automatic exp_t modelOut();
        exp_t e;
        e.grant = '0;
        if (m_owner >= 0) e.grant[m_owner] = 1'b1;
        e.idx     = 2'(m_idx);
        e.valid   = (m_owner >= 0);
        e.preempt = m_preempt;
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model and queue the expectation.
    // A reset cycle also checks that the outputs clear without a clock edge.
    task automatic applyStimulus(input logic r_rst, input logic [N-1:0] r_req,
                                 input logic [N-1:0] r_lock);
        @(negedge clk);
        rst  = r_rst;
        req  = r_req;
        lock = r_lock;
        modelStep(r_rst, r_req, r_lock);
        exp_q.push_back(modelOut());
        if (r_rst) begin
            #1;
            n_vec++;
            if (grant !== '0 || grant_valid !== 1'b0 || preempt !== 1'b0 ||
                grant_idx !== 2'd0) begin
                n_miss++;
                $display("[TB] FAIL async_reset t=%0t grant=%b idx=%0d valid=%b preempt=%b required all zero",
                         $time, grant, grant_idx, grant_valid, preempt);
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        n_vec++;
        if (grant !== e.grant || grant_idx !== e.idx ||
            grant_valid !== e.valid || preempt !== e.preempt) begin
            n_miss++;
            $display("[TB] FAIL cycle_check t=%0t got grant=%b idx=%0d valid=%b preempt=%b want grant=%b idx=%0d valid=%b preempt=%b",
                     $time, grant, grant_idx, grant_valid, preempt,
                     e.grant, e.idx, e.valid, e.preempt);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog t=%0t run did not complete, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] l;
        logic         rr;

        rst  = 1'b1;
        req  = '0;
        lock = '0;

        // Reset, single request and release back to idle.
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        repeat (3) applyStimulus(1'b0, 4'b0001, 4'b0000);
        repeat (3) applyStimulus(1'b0, 4'b0000, 4'b0000);

        // All masters requesting, each owner releasing after two grant cycles.
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_owned >= 2) r[m_owner] = 1'b0;
            applyStimulus(1'b0, r, 4'b0000);
        end

        // Long tenure by master 0 with master 2 waiting, unlocked then locked.
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        repeat (2)  applyStimulus(1'b0, 4'b0001, 4'b0000);
        repeat (30) applyStimulus(1'b0, 4'b0101, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        repeat (2)  applyStimulus(1'b0, 4'b0001, 4'b0001);
        repeat (30) applyStimulus(1'b0, 4'b0101, 4'b0001);

        // Reset in the middle of a master-1 tenure, then everybody requests.
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        repeat (4) applyStimulus(1'b0, 4'b0010, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 4'b0000);
        repeat (6) applyStimulus(1'b0, 4'b1111, 4'b0000);

        // Random tenures, sparse locks and occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 14);
                r[i] = (rem[i] != 0);
                if (rem[i] != 0) rem[i]--;
                l[i] = ($urandom_range(0, 7) == 0);
            end
            rr = ($urandom_range(0, 149) == 0);
            applyStimulus(rr, r, l);
        end
        applyStimulus(1'b0, 4'b0000, 4'b0000);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL drain pending=%0d required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
